mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Initiator side of the data-memory interface. Accepts byte/half/word load and store requests from the MEM pipeline stage and drives the single-port 1024×32 data RAM (one registered read or one write per clock, no byte enables). Performs lane extraction and sign/zero extension for loads, and read-modify-write for sub-word stores. Returns one response per request.

## Interface
- MEM_AW, 10, word-address width of the data RAM; byte address bits [MEM_AW+1:2] select the word
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  loads: sign-extend when 1, zero-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  request rejected (misaligned/reserved); meaningful only with rsp_valid
- MEM_WrEn  out  1  RAM write enable
- ALU_MEM_Addr  out  MEM_AW  RAM word address
- MEM_DataIn  out  32  RAM write data
- MEM_DataOut  in  32  RAM read data, valid the cycle after the RAM edge with MEM_WrEn=0

## Operation
- Handshake: accept on rising edge with req_valid && req_ready; request fields latched at that edge. Requester holds fields until accepted.
- Little-endian lanes: byte k (addr[1:0]=k) = bits [8k+7:8k]; half at addr[1] = bits [16·addr[1]+15:16·addr[1]].
- States: IDLE, RD, CAP, WR, RESP.
  - Load: IDLE→RD→CAP→RESP→IDLE. RD presents address with MEM_WrEn=0; CAP samples MEM_DataOut, extracts, extends, registers rsp_rdata.
  - Word store: IDLE→WR→RESP→IDLE.
  - Sub-word store: IDLE→RD→CAP→WR→RESP→IDLE. CAP merges req_wdata lane into MEM_DataOut; WR writes merged word.
  - Error: IDLE→RESP→IDLE, no memory write.
- MEM_WrEn = (state==WR) && rst_n. ALU_MEM_Addr = latched addr[MEM_AW+1:2]. MEM_DataIn = merge/store register.
- Address bits above MEM_AW+1 ignored (wrap modulo 4·2^MEM_AW bytes).
- RAM reads outside RD are harmless; MEM_DataOut is sampled only in CAP.

## Timing
- Latency, accept edge to rsp_valid cycle: error 1, word store 2, load 3, sub-word store 4.
- rsp_valid high exactly one cycle (RESP); rsp_rdata/rsp_err hold until next RESP.
- Throughput: next accept earliest in the cycle after RESP.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, MEM_WrEn 0, ALU_MEM_Addr 0, MEM_DataIn 0.
- Reset mid-operation: in-flight request aborted with no response; rst_n low during WR suppresses the write, RAM unchanged.
- req_valid low in IDLE: no state change, no RAM write.

## Configuration
- MAU_MISALIGN_TRAP_EN defined: half with addr[0]=1, word with addr[1:0]≠0, or size 11 → error path, rsp_err=1, rsp_rdata=0.
- Undefined: low address bits forced to alignment (half clears bit 0, word clears [1:0]); size 11 treated as word; rsp_err tied 0.

## Structure
- Package mau_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, default MEM_AW.
- Sub-module mau_lane_align (combinational): load extract/extend and store merge from word, addr[1:0], size, signed.

## Test plan
- SW 0x010 data 0xDEADBEEF → one MEM_WrEn cycle, ALU_MEM_Addr=4, MEM_DataIn=0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_rdata=0.
- After it, LB signed 0x013 → 0xFFFFFFDE; LBU 0x010 → 0x000000EF; LHU 0x012 → 0x0000DEAD; each 3 cycles after accept.
- SB 0x011 data 0x00000055 → RD then WR with MEM_DataIn=0xDEAD55EF; following LW 0x010 → 0xDEAD55EF.
- LH 0x011: with macro → rsp_err=1 one cycle after accept, no write; without → returns half at 0x010 (0x000055EF for LHU), rsp_err=0.
- SH 0x012 with rst_n low in WR cycle → MEM_WrEn stays 0, no rsp_valid, req_ready=1 next cycle, LW 0x010 still 0xDEAD55EF.
- req_valid held high for two LWs → req_ready low from accept through RESP; second accept in the cycle after first rsp_valid.

Source files
------------

// File: rtl/mau_pkg.sv
// mau_pkg: shared size encodings, FSM state type and default RAM geometry for mem_access_unit.
package mau_pkg;
  localparam int MEM_AW_DEFAULT = 10;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_CAP, ST_WR, ST_RESP} state_e;
endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: little-endian load extract/extend and sub-word store merge on one RAM word.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [15:0] wdata_i,
  input  logic [1:0]  lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word_i[{lo_i, 3'b000} +: 8];
  assign h = lo_i[1] ? word_i[31:16] : word_i[15:0];
  assign load_o = (size_i == SZ_BYTE) ? {{24{signed_i & b[7]}}, b} :
                  (size_i == SZ_HALF) ? {{16{signed_i & h[15]}}, h} : word_i;
  always_comb begin
    merge_o = word_i;
    if (size_i == SZ_BYTE) merge_o[{lo_i, 3'b000} +: 8] = wdata_i[7:0];
    else if (size_i == SZ_HALF) merge_o[{lo_i[1], 4'b0000} +: 16] = wdata_i;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store initiator for a single-port registered-read data RAM.
// Define MAU_MISALIGN_TRAP_EN to reject misaligned or reserved-size requests instead of aligning them.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              MEM_WrEn,
  output logic [MEM_AW-1:0] ALU_MEM_Addr,
  output logic [31:0]       MEM_DataIn,
  input  logic [31:0]       MEM_DataOut
);
  state_e            state_q;
  logic              we_q, sgn_q, rsp_valid_q, rsp_err_q, err_d;
  logic [1:0]        size_q, size_d, lo_d;
  logic [MEM_AW+1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [31:0]       rsp_rdata_q, din_q, load_w, merge_w;
  logic              unused_hi;
  assign unused_hi = ^req_addr[31:MEM_AW+2];
`ifdef MAU_MISALIGN_TRAP_EN
  assign err_d  = (req_size == SZ_RSVD) || (req_size == SZ_HALF && req_addr[0]) ||
                  (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
  assign size_d = req_size;
  assign lo_d   = req_addr[1:0];
`else
  assign err_d  = 1'b0;
  assign size_d = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
  assign lo_d   = (size_d == SZ_BYTE) ? req_addr[1:0] :
                  (size_d == SZ_HALF) ? {req_addr[1], 1'b0} : 2'b00;
`endif
  mau_lane_align u_align (
    .word_i  (MEM_DataOut),
    .wdata_i (wdata_q),
    .lo_i    (addr_q[1:0]),
    .size_i  (size_q),
    .signed_i(sgn_q),
    .load_o  (load_w),
    .merge_o (merge_w)
  );
  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign MEM_WrEn     = (state_q == ST_WR) && rst_n;
  assign ALU_MEM_Addr = addr_q[MEM_AW+1:2];
  assign MEM_DataIn   = din_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      sgn_q       <= 1'b0;
      size_q      <= SZ_BYTE;
      addr_q      <= '0;
      wdata_q     <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid) begin
          we_q    <= req_we;
          sgn_q   <= req_signed;
          size_q  <= size_d;
          addr_q  <= {req_addr[MEM_AW+1:2], lo_d};
          wdata_q <= req_wdata[15:0];
          if (err_d) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end else if (req_we && size_d == SZ_WORD) begin
            state_q <= ST_WR;
            din_q   <= req_wdata;
          end else state_q <= ST_RD;
        end
        ST_RD: state_q <= ST_CAP;
        // Sub-word stores reuse the read path and write back the merged word.
        ST_CAP: if (we_q) begin
          din_q   <= merge_w;
          state_q <= ST_WR;
        end else begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= load_w;
          rsp_err_q   <= 1'b0;
        end
        ST_WR: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench with a behavioural 1024x32 registered-read RAM.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, MEM_WrEn;
  logic [31:0] rsp_rdata, MEM_DataIn;
  logic [31:0] MEM_DataOut = '0;
  logic [9:0]  ALU_MEM_Addr;
  logic [31:0] ram [0:1023];
  int          checks = 0, errors = 0, wr_cnt = 0;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .MEM_WrEn(MEM_WrEn),
    .ALU_MEM_Addr(ALU_MEM_Addr), .MEM_DataIn(MEM_DataIn), .MEM_DataOut(MEM_DataOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (MEM_WrEn) ram[ALU_MEM_Addr] <= MEM_DataIn;
    MEM_DataOut <= ram[ALU_MEM_Addr];
  end

  always @(posedge clk) if (MEM_WrEn) begin
    wr_cnt  = wr_cnt + 1;
    wr_addr = ALU_MEM_Addr;
    wr_data = MEM_DataIn;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic op(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] wd,
                    input int exp_lat, input logic [31:0] exp_rd, input logic exp_err, input int exp_wr);
    int lat, wr0;
    logic [31:0] rd;
    logic er;
    @(negedge clk);
    wr0 = wr_cnt;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = n; rd = rsp_rdata; er = rsp_err; end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
    chk({tag, "_wrs"}, wr_cnt - wr0, exp_wr);
    @(negedge clk);
    chk({tag, "_oneshot"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int wr0, ready_bad;
    int rsp_at [2];
    int nrsp;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_wren", {31'b0, MEM_WrEn}, 32'd0);
    chk("rst_addr", {22'b0, ALU_MEM_Addr}, 32'd0);
    chk("rst_din", MEM_DataIn, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_wr", wr_cnt, 0);

    op("sw", 1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
    chk("sw_addr", {22'b0, wr_addr}, 32'd4);
    chk("sw_data", wr_data, 32'hDEADBEEF);
    op("lb", 1'b0, 2'b00, 1'b1, 32'h013, 32'h0, 3, 32'hFFFFFFDE, 1'b0, 0);
    op("lbu", 1'b0, 2'b00, 1'b0, 32'h010, 32'h0, 3, 32'h000000EF, 1'b0, 0);
    op("lhu", 1'b0, 2'b01, 1'b0, 32'h012, 32'h0, 3, 32'h0000DEAD, 1'b0, 0);
    op("lh", 1'b0, 2'b01, 1'b1, 32'h012, 32'h0, 3, 32'hFFFFDEAD, 1'b0, 0);
    op("lw_wrap", 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0);
    op("sb", 1'b1, 2'b00, 1'b0, 32'h011, 32'h00000055, 4, 32'h0, 1'b0, 1);
    chk("sb_addr", {22'b0, wr_addr}, 32'd4);
    chk("sb_data", wr_data, 32'hDEAD55EF);
    op("lw", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 3, 32'hDEAD55EF, 1'b0, 0);
`ifdef MAU_MISALIGN_TRAP_EN
    op("lh_mis", 1'b0, 2'b01, 1'b0, 32'h011, 32'h0, 1, 32'h0, 1'b1, 0);
    op("sw_mis", 1'b1, 2'b10, 1'b0, 32'h012, 32'h12345678, 1, 32'h0, 1'b1, 0);
`else
    op("lh_mis", 1'b0, 2'b01, 1'b0, 32'h011, 32'h0, 3, 32'h000055EF, 1'b0, 0);
    op("lrsvd", 1'b0, 2'b11, 1'b0, 32'h013, 32'h0, 3, 32'hDEAD55EF, 1'b0, 0);
`endif

    // Reset lands on the WR cycle of a sub-word store: edges after accept are RD, CAP, WR.
    @(negedge clk);
    wr0 = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h012; req_wdata = 32'h00001234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    nrsp = 0;
    repeat (2) begin @(posedge clk); #1; if (rsp_valid) nrsp++; end
    rst_n = 1'b0;
    #1 chk("rstwr_wren", {31'b0, MEM_WrEn}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    if (rsp_valid) nrsp++;
    chk("rstwr_ready", {31'b0, req_ready}, 32'd1);
    chk("rstwr_norsp", nrsp, 0);
    chk("rstwr_nowr", wr_cnt - wr0, 0);
    op("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 3, 32'hDEAD55EF, 1'b0, 0);

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h010;
    @(posedge clk);
    nrsp = 0; ready_bad = 0; rsp_at[0] = 0; rsp_at[1] = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 5) req_valid = 1'b0;
      if (rsp_valid && nrsp < 2) begin
        rsp_at[nrsp] = n;
        chk($sformatf("b2b_rdata%0d", nrsp), rsp_rdata, 32'hDEAD55EF);
        nrsp++;
      end
      if ((n <= 3 || (n >= 5 && n <= 7)) && req_ready) ready_bad++;
      if (n == 4 && !req_ready) ready_bad++;
    end
    chk("b2b_rsp1", rsp_at[0], 3);
    chk("b2b_rsp2", rsp_at[1], 7);
    chk("b2b_ready", ready_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
